riscv_ifu: RTL

Instruction fetch unit for the RISC-V core: generates word-aligned fetch requests on the instruction bus and realigns returned 32-bit words into a halfword buffer. It emits one instruction per handshake, either 16-bit compressed or 32-bit, sized by `riscv_isa_pkg::opsiz`. It sits between instruction memory and the decoder, and accepts PC redirects from the branch/jump unit.

---
 rtl/riscv_isa_pkg.sv | 16 +
 rtl/riscv_ifu_hwb.sv | 57 +++++
 rtl/riscv_ifu.sv | 113 +++++++++++
 3 files changed

// File: rtl/riscv_isa_pkg.sv
// Shared RISC-V ISA helpers for the core.
//   opsiz()        : instruction size in bytes (2 or 4) from its first halfword
//   IFU_HWB_DEPTH  : halfword capacity of the fetch realignment buffer
package riscv_isa_pkg;

  localparam int IFU_HWB_DEPTH = 4;

  typedef logic [15:0] hw_t;

  // Low two opcode bits 2'b11 mark a 32-bit instruction; anything else is
  // a 16-bit compressed one. The mask form reads every bit of the argument.
  function automatic logic [2:0] opsiz(input hw_t op);
    return ((op & 16'h0003) == 16'h0003) ? 3'd4 : 3'd2;
  endfunction

endpackage

// File: rtl/riscv_ifu_hwb.sv
// Halfword shift buffer for instruction realignment.
//   clk, rst      : clock, asynchronous active-high reset
//   i_flush       : drop all held halfwords (wins over consume/append)
//   i_cons        : halfwords removed from the head this cycle (0..2)
//   i_app_n       : halfwords appended this cycle (0..2)
//   i_app_dat     : appended data, lower halfword goes in first
//   o_hw0, o_hw1  : two oldest halfwords (head first)
//   o_cnt         : halfwords held (0..IFU_HWB_DEPTH)
module riscv_ifu_hwb
  import riscv_isa_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic [1:0]  i_cons,
  input  logic [1:0]  i_app_n,
  input  logic [31:0] i_app_dat,
  output logic [15:0] o_hw0,
  output logic [15:0] o_hw1,
  output logic [2:0]  o_cnt
);

  logic [16*IFU_HWB_DEPTH-1:0] r_buf;
  logic [2:0]                  r_cnt;
  logic [16*IFU_HWB_DEPTH-1:0] w_nxt;
  logic [2:0]                  w_cnt_s;

  // Consumption shifts the head out first; the new halfwords then land
  // right after whatever survives the shift.
  always_comb begin
    w_cnt_s = r_cnt - {1'b0, i_cons};
    w_nxt   = r_buf >> {i_cons, 4'b0000};
    for (int k = 0; k < IFU_HWB_DEPTH; k++) begin
      if (i_app_n != 2'd0 && w_cnt_s == 3'(k))
        w_nxt[16*k +: 16] = i_app_dat[15:0];
      if (i_app_n == 2'd2 && (w_cnt_s + 3'd1) == 3'(k))
        w_nxt[16*k +: 16] = i_app_dat[31:16];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf <= '0;
      r_cnt <= 3'd0;
    end else if (i_flush) begin
      r_cnt <= 3'd0;
    end else begin
      r_buf <= w_nxt;
      r_cnt <= w_cnt_s + {1'b0, i_app_n};
    end
  end

  assign o_hw0 = r_buf[15:0];
  assign o_hw1 = r_buf[31:16];
  assign o_cnt = r_cnt;

endmodule

// File: rtl/riscv_ifu.sv
// RISC-V instruction fetch unit: issues word-aligned fetches, realigns the
// returned words through a halfword buffer and hands out one 16- or 32-bit
// instruction per handshake. PC redirects flush everything in flight.
//   clk, rst                   : clock, asynchronous active-high reset
//   i_jmp_vld, i_jmp_adr       : redirect strobe and target (bit 0 ignored)
//   o_ifb_vld, o_ifb_adr       : fetch request, word address
//   i_ifb_rdy, i_ifb_rdt       : request accept, read data one cycle later
//   o_ins_vld, i_ins_rdy       : instruction handshake to the decoder
//   o_ins_pc, o_ins_op, o_ins_siz : instruction address, bits, size in bytes
//
// Handshakes: a transfer happens on a cycle where valid & ready are both
// high; valid never waits for ready, and request/instruction fields stay
// stable while valid is high and ready is low (a redirect may cancel them).
module riscv_ifu
  import riscv_isa_pkg::*;
#(
  parameter logic [31:0] PC_RST = 32'h0000_0000,
  parameter logic        CEXT   = 1'b1
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_jmp_vld,
  input  logic [31:0] i_jmp_adr,
  output logic        o_ifb_vld,
  output logic [31:0] o_ifb_adr,
  input  logic        i_ifb_rdy,
  input  logic [31:0] i_ifb_rdt,
  output logic        o_ins_vld,
  input  logic        i_ins_rdy,
  output logic [31:0] o_ins_pc,
  output logic [31:0] o_ins_op,
  output logic [2:0]  o_ins_siz
);

  logic [31:0] r_pc;
  logic [31:0] r_fad;
  logic        r_pnd;
  logic        r_skp;

  logic [15:0] w_hw0;
  logic [15:0] w_hw1;
  logic [2:0]  w_cnt;
  logic [2:0]  w_siz;
  logic [3:0]  w_occ;
  logic        w_ins_vld;
  logic        w_ifb_vld;
  logic        w_ifb_hs;
  logic        w_ins_hs;
  logic [1:0]  w_cons;
  logic [1:0]  w_app_n;
  logic [31:0] w_app_dat;

  assign w_siz     = CEXT ? opsiz(w_hw0) : 3'd4;
  assign w_ins_vld = (w_siz == 3'd2 && w_cnt >= 3'd1) ||
                     (w_siz == 3'd4 && w_cnt >= 3'd2);

  // Buffered plus in-flight halfwords; fetching only while this is <= 2
  // keeps the 4-deep buffer from ever overflowing.
  assign w_occ     = {1'b0, w_cnt} + {2'b00, r_pnd, 1'b0};
  assign w_ifb_vld = !rst && !i_jmp_vld && (w_occ <= 4'd2);
  assign w_ifb_hs  = w_ifb_vld && i_ifb_rdy;

  // A handshake in a redirect cycle is accepted but leaves no trace.
  assign w_ins_hs  = w_ins_vld && i_ins_rdy && !i_jmp_vld;
  assign w_cons    = w_ins_hs ? w_siz[2:1] : 2'd0;

  // After a halfword-aligned redirect the first response carries one
  // halfword before the target, which is dropped.
  assign w_app_n   = (!r_pnd || i_jmp_vld) ? 2'd0 : (r_skp ? 2'd1 : 2'd2);
  assign w_app_dat = r_skp ? {16'h0000, i_ifb_rdt[31:16]} : i_ifb_rdt;

  riscv_ifu_hwb u_hwb (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (i_jmp_vld),
    .i_cons    (w_cons),
    .i_app_n   (w_app_n),
    .i_app_dat (w_app_dat),
    .o_hw0     (w_hw0),
    .o_hw1     (w_hw1),
    .o_cnt     (w_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc  <= PC_RST;
      r_fad <= PC_RST & ~32'h3;
      r_pnd <= 1'b0;
      r_skp <= PC_RST[1];
    end else if (i_jmp_vld) begin
      r_pc  <= i_jmp_adr & ~32'h1;
      r_fad <= i_jmp_adr & ~32'h3;
      r_pnd <= 1'b0;
      r_skp <= i_jmp_adr[1];
    end else begin
      r_pnd <= w_ifb_hs;
      if (w_ifb_hs) r_fad <= r_fad + 32'd4;
      if (w_ins_hs) r_pc  <= r_pc + {29'd0, w_siz};
      if (r_pnd)    r_skp <= 1'b0;
    end
  end

  assign o_ifb_vld = w_ifb_vld;
  assign o_ifb_adr = r_fad;
  assign o_ins_vld = w_ins_vld;
  assign o_ins_pc  = r_pc;
  // An empty buffer presents the idle values (op 0, size 4) rather than
  // whatever stale halfwords remain after a flush.
  assign o_ins_siz = (w_cnt == 3'd0) ? 3'd4 : w_siz;
  assign o_ins_op  = (w_cnt == 3'd0) ? 32'h0 :
                     (w_siz == 3'd4) ? {w_hw1, w_hw0} : {16'h0000, w_hw0};

endmodule
